// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Drives a multiplexed, common-anode 7-segment display bank. DIGITS hex
//   nibbles are time-multiplexed onto one shared segment bus. An all-off
//   blanking gap separates the digit windows to prevent ghosting. Display
//   data is snapshotted once per frame, so a frame never mixes old and new
//   values.
//
//   Ports:
//     clk        in   system clock
//     rst        in   synchronous reset, active-low
//     en         in   scan enable; 0 turns the display dark
//     value      in   4*DIGITS hex nibbles, digit k = value[4k+3:4k]
//     dp         in   DIGITS decimal points
//     blank_mask in   DIGITS; 1 keeps digit k dark during its slot
//     seg        out  7 segments, seg[0]=a .. seg[6]=g
//     dp_out     out  decimal point segment
//     an         out  DIGITS anode selects, one-hot when active
//     frame_done out  one-cycle pulse, first cycle of each new frame
//
//   Every output is a flop fed from the current FSM state, so outputs trail
//   the state by one clock.
module seg_scan_driver #(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 40,
    parameter int BLANK      = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank_mask,
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [18:0]   BLANK_LAST = 19'(BLANK - 1);
    localparam logic [18:0]   ON_LAST    = 19'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic          POL        = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ON} state_t;

    state_t                state, state_d;
    logic [IW-1:0]         idx, idx_d;
    logic [18:0]           cnt, cnt_d;
    logic [4*DIGITS-1:0]   sh_value, sh_value_d;
    logic [DIGITS-1:0]     sh_dp, sh_dp_d;
    logic [DIGITS-1:0]     sh_mask, sh_mask_d;
    logic                  wrap_q, wrap_d;

    logic [3:0]            nib;
    logic [6:0]            seg_act;
    logic                  dp_act;
    logic [DIGITS-1:0]     an_act;
    logic                  fd_act;

    function automatic logic [6:0] hex_decode(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b0111111;
            4'h1: s = 7'b0000110;
            4'h2: s = 7'b1011011;
            4'h3: s = 7'b1001111;
            4'h4: s = 7'b1100110;
            4'h5: s = 7'b1101101;
            4'h6: s = 7'b1111101;
            4'h7: s = 7'b0000111;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1101111;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b1111100;
            4'hC: s = 7'b0111001;
            4'hD: s = 7'b1011110;
            4'hE: s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            cnt      <= '0;
            sh_value <= '0;
            sh_dp    <= '0;
            sh_mask  <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state    <= state_d;
            idx      <= idx_d;
            cnt      <= cnt_d;
            sh_value <= sh_value_d;
            sh_dp    <= sh_dp_d;
            sh_mask  <= sh_mask_d;
            wrap_q   <= wrap_d;
        end
    end

    // Next-state logic. A slot always starts in BLANK unless BLANK is 0.
    always_comb begin
        state_d    = state;
        idx_d      = idx;
        cnt_d      = cnt + 19'd1;
        sh_value_d = sh_value;
        sh_dp_d    = sh_dp;
        sh_mask_d  = sh_mask;
        wrap_d     = 1'b0;
        if (!en) begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    sh_value_d = value;
                    sh_dp_d    = dp;
                    sh_mask_d  = blank_mask;
                    idx_d      = '0;
                    cnt_d      = '0;
                    state_d    = (BLANK > 0) ? S_BLANK : S_ON;
                end
                S_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_d = S_ON;
                        cnt_d   = '0;
                    end
                end
                S_ON: begin
                    if (cnt == ON_LAST) begin
                        cnt_d   = '0;
                        state_d = (BLANK > 0) ? S_BLANK : S_ON;
                        if (idx == IDX_LAST) begin
                            // Frame boundary: restart at digit 0 with fresh data.
                            idx_d      = '0;
                            sh_value_d = value;
                            sh_dp_d    = dp;
                            sh_mask_d  = blank_mask;
                            wrap_d     = 1'b1;
                        end else begin
                            idx_d = idx + IW'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output logic, active-high; polarity is applied at the output flops.
    // seg/dp already show the digit during BLANK so the bus settles before
    // the anode turns on.
    always_comb begin
        nib     = sh_value[{idx, 2'b00} +: 4];
        seg_act = 7'b0;
        dp_act  = 1'b0;
        an_act  = '0;
        // wrap_q marks the first cycle of a new frame; a dropped enable
        // suppresses it.
        fd_act  = wrap_q & en;
        if (state != S_IDLE) begin
            seg_act = hex_decode(nib);
            dp_act  = sh_dp[idx];
            if (state == S_ON && !sh_mask[idx])
                an_act = DIGITS'(1) << idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            seg        <= {7{POL}};
            dp_out     <= POL;
            an         <= {DIGITS{POL}};
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_act ^ {7{POL}};
            dp_out     <= dp_act ^ POL;
            an         <= an_act ^ {DIGITS{POL}};
            frame_done <= fd_act;
        end
    end

endmodule
